// File: rtl/sram_rd_resp_buf_if.sv
// Request/response handshake bundle for the SRAM read-response buffer.
// The slave modport is the buffer itself; the master modport is the
// cache-side requester that issues reads and consumes response words.
interface sram_rd_resp_buf_if #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 2,
  parameter int WMASK_WIDTH = 4
);
  logic                                    req_valid;
  logic                                    req_ready;
  logic [ADDR_WIDTH-1:0]                   req_addr;
  logic                                    resp_valid;
  logic                                    resp_ready;
  logic [WMASK_WIDTH-1:0][DATA_WIDTH-1:0]  resp_data;

  modport slave (
    input  req_valid,
    input  req_addr,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_data
  );

  modport master (
    output req_valid,
    output req_addr,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );
endinterface

// File: rtl/sram_rd_resp_buf.sv
// Decoupled read front-end for a 1-cycle-latency synchronous-read SRAM.
// Requests go straight to the SRAM; the returned word is either handed
// downstream in the same cycle (bypass) or parked in a 2-entry skid FIFO
// so it survives the SRAM output register being overwritten.
module sram_rd_resp_buf #(
  parameter int DEEPTH      = 2048,
  parameter int DATA_WIDTH  = 2,
  parameter int WMASK_WIDTH = 4,
  parameter int ADDR_WIDTH  = $clog2(DEEPTH)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    flush,
  sram_rd_resp_buf_if.slave                       bus,
  output logic                                    mem_ren,
  output logic [ADDR_WIDTH-1:0]                   mem_raddr,
  input  logic [WMASK_WIDTH-1:0][DATA_WIDTH-1:0]  mem_rdata,
  output logic [1:0]                              occupancy
);

  typedef logic [WMASK_WIDTH-1:0][DATA_WIDTH-1:0] word_t;

  // Control state: read in flight, FIFO pointers and fill level.
  logic       pend_q,   pend_d;
  logic [1:0] occ_q,    occ_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;

  // Skid storage; deliberately never reset, occ_q says what is live.
  word_t      fifo_q [2];

  logic [1:0] outstanding;
  logic       fifo_nempty;
  logic       capture;
  logic       pop;
  logic       accept;

  // Handshake and datapath steering, derived from registered state only.
  always_comb begin
    outstanding    = occ_q + {1'b0, pend_q};
    fifo_nempty    = (occ_q != 2'd0);

    bus.req_ready  = rst_n && !flush && (outstanding < 2'd2);
    accept         = bus.req_valid && bus.req_ready;
    mem_ren        = accept;
    mem_raddr      = bus.req_addr;

    bus.resp_valid = rst_n && !flush && (fifo_nempty || pend_q);
    bus.resp_data  = fifo_nempty ? fifo_q[rd_ptr_q] : mem_rdata;

    // The in-flight word must be parked unless it leaves via bypass now.
    capture        = pend_q && (fifo_nempty || !bus.resp_ready);
    pop            = bus.resp_valid && bus.resp_ready && fifo_nempty;

    occupancy      = rst_n ? occ_q : 2'd0;
  end

  // Next-state for the control registers; flush and reset both empty the buffer.
  always_comb begin
    pend_d   = accept;
    occ_d    = occ_q + {1'b0, capture} - {1'b0, pop};
    wr_ptr_d = wr_ptr_q ^ capture;
    rd_ptr_d = rd_ptr_q ^ pop;
    if (flush) begin
      pend_d   = 1'b0;
      occ_d    = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  // Control register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q   <= 1'b0;
      occ_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Park the SRAM output word into the skid FIFO when it is not consumed.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && capture) begin
      fifo_q[wr_ptr_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_sram_rd_resp_buf.sv
// Directed bench for sram_rd_resp_buf with a behavioural 1-cycle SRAM.
module tb_sram_rd_resp_buf;
  localparam int DEEPTH = 2048;
  localparam int DW     = 2;
  localparam int WM     = 4;
  localparam int AW     = $clog2(DEEPTH);

  logic clk;
  logic rst_n;
  logic flush;
  logic mem_ren;
  logic [AW-1:0] mem_raddr;
  logic [WM-1:0][DW-1:0] mem_rdata;
  logic [1:0] occupancy;

  logic [7:0] sram [DEEPTH];

  int nchk = 0;
  int nerr = 0;

  sram_rd_resp_buf_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(WM)) bus ();

  sram_rd_resp_buf #(.DEEPTH(DEEPTH), .DATA_WIDTH(DW), .WMASK_WIDTH(WM)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read SRAM: data appears the cycle after ren, held otherwise.
  always @(posedge clk) if (mem_ren) mem_rdata <= sram[mem_raddr];

  function automatic logic [7:0] exp_word(input int a);
    if (a == 5) return 8'h5A;
    return 8'((a * 37 + 11) & 255);
  endfunction

  // Advance to the next negedge, apply inputs, then let combinational logic settle.
  task automatic drive(input logic rn, input logic fl, input logic rv, input int addr, input logic rr);
    @(negedge clk);
    rst_n = rn; flush = fl;
    bus.req_valid = rv; bus.req_addr = AW'(addr); bus.resp_ready = rr;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b1, 3, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 3, 1'b1);
    nchk++; if (bus.req_ready !== 1'b0) begin nerr++; $display("FAIL rst_req_ready got=%b want=0", bus.req_ready); end
    nchk++; if (mem_ren !== 1'b0) begin nerr++; $display("FAIL rst_mem_ren got=%b want=0", mem_ren); end
    nchk++; if (bus.resp_valid !== 1'b0) begin nerr++; $display("FAIL rst_resp_valid got=%b want=0", bus.resp_valid); end
    nchk++; if (occupancy !== 2'd0) begin nerr++; $display("FAIL rst_occ got=%0d want=0", occupancy); end
    drive(1'b1, 1'b0, 1'b0, 0, 1'b1);
    nchk++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL post_rst_req_ready got=%b want=1", bus.req_ready); end
    nchk++; if (bus.resp_valid !== 1'b0) begin nerr++; $display("FAIL post_rst_resp_valid got=%b want=0", bus.resp_valid); end
  endtask

  task automatic test_single(input string tag);
    drive(1'b1, 1'b0, 1'b1, 5, 1'b1);
    nchk++; if (mem_ren !== 1'b1) begin nerr++; $display("FAIL %s_ren got=%b want=1", tag, mem_ren); end
    nchk++; if (mem_raddr !== AW'(5)) begin nerr++; $display("FAIL %s_raddr got=%0d want=5", tag, mem_raddr); end
    nchk++; if (bus.resp_valid !== 1'b0) begin nerr++; $display("FAIL %s_early_valid got=%b want=0", tag, bus.resp_valid); end
    drive(1'b1, 1'b0, 1'b0, 0, 1'b1);
    nchk++; if (bus.resp_valid !== 1'b1) begin nerr++; $display("FAIL %s_valid got=%b want=1", tag, bus.resp_valid); end
    nchk++; if (bus.resp_data !== 8'h5A) begin nerr++; $display("FAIL %s_data got=%h want=5a", tag, bus.resp_data); end
    nchk++; if (occupancy !== 2'd0) begin nerr++; $display("FAIL %s_occ got=%0d want=0", tag, occupancy); end
    drive(1'b1, 1'b0, 1'b0, 0, 1'b1);
    nchk++; if (bus.resp_valid !== 1'b0) begin nerr++; $display("FAIL %s_after_valid got=%b want=0", tag, bus.resp_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= 8; i++) begin
      drive(1'b1, 1'b0, (i < 8), i, 1'b1);
      if (i < 8) begin
        nchk++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, bus.req_ready); end
      end
      if (i > 0) begin
        nchk++; if (bus.resp_valid !== 1'b1) begin nerr++; $display("FAIL b2b_valid[%0d] got=%b want=1", i, bus.resp_valid); end
        nchk++; if (bus.resp_data !== exp_word(i - 1)) begin nerr++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, bus.resp_data, exp_word(i - 1)); end
      end
      nchk++; if (occupancy !== 2'd0) begin nerr++; $display("FAIL b2b_occ[%0d] got=%0d want=0", i, occupancy); end
    end
    drive(1'b1, 1'b0, 1'b0, 0, 1'b1);
    nchk++; if (bus.resp_valid !== 1'b0) begin nerr++; $display("FAIL b2b_tail_valid got=%b want=0", bus.resp_valid); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 1'b0, 1'b1, 1, 1'b0);
    nchk++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL bp_acc1 got=%b want=1", bus.req_ready); end
    drive(1'b1, 1'b0, 1'b1, 2, 1'b0);
    nchk++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL bp_acc2 got=%b want=1", bus.req_ready); end
    nchk++; if (bus.resp_data !== exp_word(1)) begin nerr++; $display("FAIL bp_bypass got=%h want=%h", bus.resp_data, exp_word(1)); end
    drive(1'b1, 1'b0, 1'b1, 3, 1'b0);
    nchk++; if (bus.req_ready !== 1'b0) begin nerr++; $display("FAIL bp_full_ready got=%b want=0", bus.req_ready); end
    nchk++; if (occupancy !== 2'd1) begin nerr++; $display("FAIL bp_occ1 got=%0d want=1", occupancy); end
    nchk++; if (bus.resp_data !== exp_word(1)) begin nerr++; $display("FAIL bp_hold1 got=%h want=%h", bus.resp_data, exp_word(1)); end
    drive(1'b1, 1'b0, 1'b1, 3, 1'b0);
    nchk++; if (occupancy !== 2'd2) begin nerr++; $display("FAIL bp_occ2 got=%0d want=2", occupancy); end
    nchk++; if (bus.req_ready !== 1'b0) begin nerr++; $display("FAIL bp_occ2_ready got=%b want=0", bus.req_ready); end
    nchk++; if (mem_ren !== 1'b0) begin nerr++; $display("FAIL bp_occ2_ren got=%b want=0", mem_ren); end
    drive(1'b1, 1'b0, 1'b1, 3, 1'b1);
    nchk++; if (bus.req_ready !== 1'b0) begin nerr++; $display("FAIL bp_pop_ready got=%b want=0", bus.req_ready); end
    nchk++; if (bus.resp_data !== exp_word(1)) begin nerr++; $display("FAIL bp_out1 got=%h want=%h", bus.resp_data, exp_word(1)); end
    drive(1'b1, 1'b0, 1'b1, 3, 1'b1);
    nchk++; if (mem_ren !== 1'b1) begin nerr++; $display("FAIL bp_acc3 got=%b want=1", mem_ren); end
    nchk++; if (bus.resp_data !== exp_word(2)) begin nerr++; $display("FAIL bp_out2 got=%h want=%h", bus.resp_data, exp_word(2)); end
    nchk++; if (occupancy !== 2'd1) begin nerr++; $display("FAIL bp_occ_drain got=%0d want=1", occupancy); end
    drive(1'b1, 1'b0, 1'b0, 0, 1'b1);
    nchk++; if (bus.resp_valid !== 1'b1) begin nerr++; $display("FAIL bp_valid3 got=%b want=1", bus.resp_valid); end
    nchk++; if (bus.resp_data !== exp_word(3)) begin nerr++; $display("FAIL bp_out3 got=%h want=%h", bus.resp_data, exp_word(3)); end
    nchk++; if (occupancy !== 2'd0) begin nerr++; $display("FAIL bp_occ_end got=%0d want=0", occupancy); end
    drive(1'b1, 1'b0, 1'b0, 0, 1'b1);
    nchk++; if (bus.resp_valid !== 1'b0) begin nerr++; $display("FAIL bp_idle got=%b want=0", bus.resp_valid); end
  endtask

  task automatic test_toggle();
    int q[$];
    int next_addr = 16;
    int issued = 0;
    int got = 0;
    for (int k = 0; k < 40; k++) begin
      logic rr;
      logic rv;
      rr = (k % 2 == 0) && (k < 20);
      if (k >= 20) rr = 1'b1;
      rv = (k < 20);
      drive(1'b1, 1'b0, rv, next_addr, rr);
      if (bus.resp_valid) begin
        nchk++;
        if (q.size() == 0) begin
          nerr++; $display("FAIL tog_spurious got=%h want=no_response", bus.resp_data);
        end else if (bus.resp_data !== exp_word(q[0])) begin
          nerr++; $display("FAIL tog_data got=%h want=%h", bus.resp_data, exp_word(q[0]));
        end
        if (rr && q.size() > 0) begin void'(q.pop_front()); got++; end
      end
      if (rv && bus.req_ready) begin q.push_back(next_addr); next_addr++; issued++; end
      if (k >= 20 && q.size() == 0) break;
    end
    nchk++; if (q.size() != 0) begin nerr++; $display("FAIL tog_drain left=%0d want=0", q.size()); end
    nchk++; if (got != issued || issued < 8) begin nerr++; $display("FAIL tog_count got=%0d issued=%0d", got, issued); end
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b0, 1'b1, 40, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 41, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 42, 1'b1);
    nchk++; if (bus.resp_valid !== 1'b0) begin nerr++; $display("FAIL fl_valid got=%b want=0", bus.resp_valid); end
    nchk++; if (bus.req_ready !== 1'b0) begin nerr++; $display("FAIL fl_ready got=%b want=0", bus.req_ready); end
    nchk++; if (mem_ren !== 1'b0) begin nerr++; $display("FAIL fl_ren got=%b want=0", mem_ren); end
    drive(1'b1, 1'b0, 1'b1, 42, 1'b1);
    nchk++; if (occupancy !== 2'd0) begin nerr++; $display("FAIL fl_occ got=%0d want=0", occupancy); end
    nchk++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL fl_ready_after got=%b want=1", bus.req_ready); end
    nchk++; if (bus.resp_valid !== 1'b0) begin nerr++; $display("FAIL fl_stale got=%b want=0", bus.resp_valid); end
    drive(1'b1, 1'b0, 1'b0, 0, 1'b1);
    nchk++; if (bus.resp_data !== exp_word(42) || bus.resp_valid !== 1'b1) begin nerr++; $display("FAIL fl_fresh got=%h/%b want=%h/1", bus.resp_data, bus.resp_valid, exp_word(42)); end
    drive(1'b1, 1'b0, 1'b0, 0, 1'b1);
    nchk++; if (bus.resp_valid !== 1'b0) begin nerr++; $display("FAIL fl_idle got=%b want=0", bus.resp_valid); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b1, 50, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 51, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 52, 1'b1);
    nchk++; if (bus.resp_valid !== 1'b0) begin nerr++; $display("FAIL rm_valid got=%b want=0", bus.resp_valid); end
    nchk++; if (bus.req_ready !== 1'b0 || mem_ren !== 1'b0) begin nerr++; $display("FAIL rm_req got=%b/%b want=0/0", bus.req_ready, mem_ren); end
    nchk++; if (occupancy !== 2'd0) begin nerr++; $display("FAIL rm_occ got=%0d want=0", occupancy); end
    drive(1'b1, 1'b0, 1'b0, 0, 1'b1);
    nchk++; if (bus.resp_valid !== 1'b0) begin nerr++; $display("FAIL rm_stale got=%b want=0", bus.resp_valid); end
    nchk++; if (occupancy !== 2'd0) begin nerr++; $display("FAIL rm_occ_after got=%0d want=0", occupancy); end
    test_single("rm");
  endtask

  initial begin
    for (int a = 0; a < DEEPTH; a++) sram[a] = exp_word(a);
    rst_n = 1'b0; flush = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.resp_ready = 1'b0;
    test_reset();
    test_single("single");
    test_back_to_back();
    test_backpressure();
    test_toggle();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
